uart_rx_deser: RTL and testbench

- Receive front end of the UART peripheral, directly upstream of the core's RX FIFO and register file.
- Takes raw asynchronous rx_i pin, synchronizes it, oversamples with a programmable baud tick and majority-votes each bit.
- Deserializes LSB-first frames; presents each byte plus error flags on a valid/ready holding register that the core pops into its FIFO.

---
 rtl/uart_rx_deser.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receive front end: synchronizes rx_i, oversamples on a programmable baud
// tick, majority-votes each bit and holds the received byte for the core.
module uart_rx_deser #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              rx_i,
  input  logic              rx_en_i,
  input  logic [15:0]       baud_div_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  input  logic              rx_ready_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_parity_err_o,
  output logic              rx_frame_err_o,
  output logic              break_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_VOTE = OVS_W'(OVS / 2 + 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_reg, state_next;
  logic                rx_meta_reg, rx_s_reg;
  logic [15:0]         tick_cnt_reg;
  logic [OVS_W-1:0]    ovs_cnt_reg;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [3:0]          bit_cnt_reg, bit_cnt_next;
  logic                stop_cnt_reg, stop_cnt_next;
  logic                perr_reg, perr_next;
  logic                ferr_reg, ferr_next;
  logic                par_en_reg, par_odd_reg, stop2_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                valid_reg, perr_out_reg, ferr_out_reg;
  logic                break_reg, overrun_reg;
  logic                tick, vote_tick, bit_end, vote;
  logic                start_det, frame_done;

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_i;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // >= guards against baud_div_i shrinking below the running count
  assign tick = (baud_div_i != 16'd0) && (tick_cnt_reg >= baud_div_i - 16'd1);
  assign vote_tick = tick && (ovs_cnt_reg == OVS_VOTE);
  assign bit_end   = tick && (ovs_cnt_reg == OVS_LAST);

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      tick_cnt_reg <= 16'd0;
      ovs_cnt_reg  <= '0;
    end else if (start_det) begin
      tick_cnt_reg <= 16'd0;
      ovs_cnt_reg  <= '0;
    end else begin
      if (tick || baud_div_i == 16'd0) tick_cnt_reg <= 16'd0;
      else                             tick_cnt_reg <= tick_cnt_reg + 16'd1;
      if (tick) ovs_cnt_reg <= (ovs_cnt_reg == OVS_LAST) ? '0 : ovs_cnt_reg + 1'b1;
    end
  end

  // The two early samples around mid-bit; the third is rx_s at the vote tick.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_samp
      logic samp_reg;
      always_ff @(posedge pclk_i) begin
        if (prst_i)
          samp_reg <= 1'b1;
        else if (tick && ovs_cnt_reg == OVS_W'(OVS / 2 - 1 + gi))
          samp_reg <= rx_s_reg;
      end
    end
  endgenerate

  assign vote = (g_samp[0].samp_reg & g_samp[1].samp_reg) |
                (g_samp[0].samp_reg & rx_s_reg) |
                (g_samp[1].samp_reg & rx_s_reg);

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= 4'd0;
      stop_cnt_reg <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      if (start_det) begin
        par_en_reg  <= parity_en_i;
        par_odd_reg <= parity_odd_i;
        stop2_reg   <= stop2_i;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    start_det     = 1'b0;
    frame_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_en_i && !rx_s_reg && baud_div_i != 16'd0) begin
          start_det     = 1'b1;
          state_next    = START;
          bit_cnt_next  = 4'd0;
          stop_cnt_next = 1'b0;
          perr_next     = 1'b0;
          ferr_next     = 1'b0;
        end
      end
      START: begin
        if (vote_tick && vote) state_next = IDLE;
        else if (bit_end)      state_next = DATA;
      end
      DATA: begin
        if (vote_tick) shift_next = {vote, shift_reg[DATA_W-1:1]};
        if (bit_end) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == BIT_LAST) state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (vote_tick) perr_next = ((^shift_reg) ^ vote) != par_odd_reg;
        if (bit_end)   state_next = STOP;
      end
      STOP: begin
        if (vote_tick) begin
          ferr_next = ferr_reg | ~vote;
          // Leave on the deciding vote so the next start edge is caught early
          if (!stop2_reg || stop_cnt_reg) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rx_en_i) begin
      state_next = IDLE;
      frame_done = 1'b0;
      start_det  = 1'b0;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      break_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      break_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      if (frame_done) begin
        break_reg <= (shift_reg == '0) && ferr_next;
        if (!valid_reg || rx_ready_i) begin
          data_reg     <= shift_reg;
          perr_out_reg <= perr_reg;
          ferr_out_reg <= ferr_next;
          valid_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && rx_ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data_o       = data_reg;
  assign rx_valid_o      = valid_reg;
  assign rx_parity_err_o = perr_out_reg;
  assign rx_frame_err_o  = ferr_out_reg;
  assign break_o         = break_reg;
  assign overrun_o       = overrun_reg;
  assign busy_o          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed plus randomized frames for uart_rx_deser, checked against a
// frame-level reference model of the expected byte and error flags.
module tb_uart_rx_deser;

  localparam int BIT_CLK = 64;

  logic        pclk = 1'b0;
  logic        prst;
  logic        rx_i;
  logic        rx_en;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_perr, rx_ferr, brk, ovr, busy;

  uart_rx_deser #(.DATA_W(8), .OVS(16)) dut (
    .pclk_i(pclk), .prst_i(prst), .rx_i(rx_i), .rx_en_i(rx_en),
    .baud_div_i(baud_div), .parity_en_i(parity_en), .parity_odd_i(parity_odd),
    .stop2_i(stop2), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .rx_parity_err_o(rx_perr), .rx_frame_err_o(rx_ferr),
    .break_o(brk), .overrun_o(ovr), .busy_o(busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: records transfers and pulse activity
  logic [7:0] got_data [0:127];
  logic       got_perr [0:127];
  logic       got_ferr [0:127];
  int got_n = 0, brk_n = 0, ovr_n = 0, vcyc_n = 0, rise_cyc = 0;
  logic valid_prev = 1'b0;
  always @(negedge pclk) begin
    if (rx_valid && rx_ready && got_n < 128) begin
      got_data[got_n] = rx_data;
      got_perr[got_n] = rx_perr;
      got_ferr[got_n] = rx_ferr;
      got_n = got_n + 1;
    end
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
    if (rx_valid) vcyc_n = vcyc_n + 1;
    if (brk) brk_n = brk_n + 1;
    if (ovr) ovr_n = ovr_n + 1;
  end

  int checks = 0;
  int errors = 0;
  int fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Reference: {break, ferr, perr, data} from what was put on the line
  function automatic logic [10:0] model(input logic [7:0] d, input logic pen, input logic podd,
                                        input logic pbit, input logic s1, input logic s2,
                                        input logic st2);
    logic perr, ferr, bk;
    int ones;
    ones = $countones(d) + int'(pbit);
    perr = pen && ((ones % 2) != int'(podd));
    ferr = (s1 == 1'b0) || (st2 && s2 == 1'b0);
    bk   = (d == 8'h00) && ferr;
    return {bk, ferr, perr, d};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic s1, input logic s2, input logic st2);
    rx_i = 1'b0;
    fall_cyc = cyc;
    step(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      step(BIT_CLK);
    end
    if (pen) begin
      rx_i = pbit;
      step(BIT_CLK);
    end
    rx_i = s1;
    step(BIT_CLK);
    if (st2) begin
      rx_i = s2;
      step(BIT_CLK);
    end
    rx_i = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic podd, input logic pbit, input logic s1,
                           input logic s2, input logic st2);
    logic [10:0] m;
    int g0, b0, o0, v0;
    parity_en = pen; parity_odd = podd; stop2 = st2;
    g0 = got_n; b0 = brk_n; o0 = ovr_n; v0 = vcyc_n;
    m = model(d, pen, podd, pbit, s1, s2, st2);
    send_frame(d, pen, pbit, s1, s2, st2);
    step(100);
    $display("frame %s: sent=0x%02h pen=%0d podd=%0d pbit=%0d stop=%0d%0d st2=%0d got=%0d",
             tag, d, pen, podd, pbit, s1, s2, st2, got_n - g0);
    check({tag, " count"}, got_n - g0, 1);
    check({tag, " valid_cycles"}, vcyc_n - v0, 1);
    if (got_n > g0) begin
      check({tag, " data"}, got_data[g0], m[7:0]);
      check({tag, " perr"}, got_perr[g0], m[8]);
      check({tag, " ferr"}, got_ferr[g0], m[9]);
    end
    check({tag, " break"}, brk_n - b0, int'(m[10]));
    check({tag, " overrun"}, ovr_n - o0, 0);
  endtask

  initial begin
    int g0, b0, o0, v0;
    logic [7:0] rd;
    logic rpen, rpodd, rpbit, rs1, rs2, rst2;

    prst = 1'b1; rx_i = 1'b1; rx_en = 1'b1; baud_div = 16'd4;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; rx_ready = 1'b1;
    step(4);
    @(negedge pclk);
    check("reset data", rx_data, 8'h00);
    check("reset valid", rx_valid, 1'b0);
    check("reset flags", {rx_perr, rx_ferr, brk, ovr}, 4'b0000);
    check("reset busy", busy, 1'b0);
    step(1);
    prst = 1'b0;
    step(20);

    run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_range("a5 latency", rise_cyc - fall_cyc, 612, 620);

    run_frame("par_even_err", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame("par_even_ok",  8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame("par_odd_ok",   8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame("frame_err",    8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("break",        8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Glitch shorter than half a bit
    parity_en = 1'b0; stop2 = 1'b0;
    g0 = got_n; v0 = vcyc_n;
    rx_i = 1'b0;
    step(8);
    rx_i = 1'b1;
    step(10);
    @(negedge pclk);
    check("glitch busy_mid", busy, 1'b1);
    step(60);
    @(negedge pclk);
    $display("glitch: busy=%0d transfers=%0d", busy, got_n - g0);
    check("glitch busy_end", busy, 1'b0);
    check("glitch no_valid", vcyc_n - v0, 0);

    // Overrun: second frame dropped while the first is held
    rx_ready = 1'b0;
    g0 = got_n; o0 = ovr_n;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(100);
    @(negedge pclk);
    $display("overrun: held=0x%02h valid=%0d pulses=%0d", rx_data, rx_valid, ovr_n - o0);
    check("ovr held_data", rx_data, 8'h11);
    check("ovr held_valid", rx_valid, 1'b1);
    check("ovr pulses", ovr_n - o0, 1);
    step(1);
    rx_ready = 1'b1;
    @(negedge pclk);
    check("ovr valid_before_pop", rx_valid, 1'b1);
    @(negedge pclk);
    check("ovr valid_dropped", rx_valid, 1'b0);
    check("ovr popped_count", got_n - g0, 1);
    if (got_n > g0) check("ovr popped_data", got_data[g0], 8'h11);

    // Reset mid-frame with a byte held
    rx_ready = 1'b0;
    step(5);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(100);
    @(negedge pclk);
    check("rst held_before", {rx_valid, rx_data}, 9'h15A);
    step(1);
    rx_i = 1'b0;
    step(5 * BIT_CLK);
    rx_i = 1'b1;
    step(32);
    @(negedge pclk);
    check("rst busy_before", busy, 1'b1);
    step(1);
    prst = 1'b1;
    step(1);
    prst = 1'b0;
    @(negedge pclk);
    $display("reset mid-frame: valid=%0d data=0x%02h busy=%0d", rx_valid, rx_data, busy);
    check("rst outputs", {rx_data, rx_valid, rx_perr, rx_ferr, brk, ovr, busy}, 14'h0);
    rx_ready = 1'b1;
    step(400);
    run_frame("after_rst", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Enable drop mid-frame
    g0 = got_n; b0 = brk_n; o0 = ovr_n; v0 = vcyc_n;
    rx_i = 1'b0;
    step(5 * BIT_CLK);
    rx_i = 1'b1;
    step(32);
    rx_en = 1'b0;
    step(1);
    @(negedge pclk);
    check("en_abort busy", busy, 1'b0);
    step(32 + 4 * BIT_CLK);
    rx_en = 1'b1;
    step(100);
    $display("enable abort: transfers=%0d breaks=%0d overruns=%0d", got_n - g0, brk_n - b0, ovr_n - o0);
    check("en_abort valid", vcyc_n - v0, 0);
    check("en_abort pulses", (brk_n - b0) + (ovr_n - o0), 0);

    // Randomized frames and configurations
    for (int k = 0; k < 8; k++) begin
      rd    = 8'($urandom_range(0, 255));
      rpen  = 1'($urandom_range(0, 1));
      rpodd = 1'($urandom_range(0, 1));
      rpbit = 1'($urandom_range(0, 1));
      rs1   = ($urandom_range(0, 3) != 0);
      rs2   = ($urandom_range(0, 3) != 0);
      rst2  = 1'($urandom_range(0, 1));
      if (k == 0) rd = 8'h00;
      run_frame($sformatf("rnd%0d", k), rd, rpen, rpodd, rpbit, rs1, rs2, rst2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
